ttt_auto_opponent: RTL and testbench

//  Automated computer player that drives the tic-tac-toe game core's move interface from the other side.

---
 rtl/ttt_pkg.sv | 40 ++++
 rtl/ttt_auto_opponent_if.sv | 24 ++
 rtl/ttt_line_eval.sv | 28 ++
 rtl/ttt_auto_opponent.sv | 153 +++++++++++++++
 tb/tb_ttt_auto_opponent.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/ttt_pkg.sv
// Shared constants, state encoding and helpers for the tic-tac-toe auto opponent.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_PLYR  = 2'b01;
  localparam logic [1:0] CELL_COMP  = 2'b10;
  localparam logic [3:0] NULL_POS   = 4'd15;

  // Eight winning lines as cell index triples; scanned in this order.
  localparam logic [3:0] LINE_TBL [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PLAY   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_SCAN   = 3'd4,
    ST_PICK   = 3'd5,
    ST_ISSUE  = 3'd6
  } state_t;

  // Number of empty cells on a board (0..9, fits 4 bits).
  function automatic logic [3:0] count_empty(input logic [8:0][1:0] b);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 9; i++)
      if (b[i] == CELL_EMPTY) n = n + 4'd1;
    return n;
  endfunction

endpackage

// File: rtl/ttt_auto_opponent_if.sv
// Move/board interface between the human side, the game core and the auto opponent.
interface ttt_auto_opponent_if;
  logic       req;
  logic [3:0] req_pos;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic [1:0] who;
  logic       play;
  logic [3:0] plyr_pos;
  logic       pc;
  logic [3:0] comp_pos;
  logic       busy;
  logic       illegal;
  logic       game_end;

  modport slave (
    input  req, req_pos, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who,
    output play, plyr_pos, pc, comp_pos, busy, illegal, game_end
  );

  modport master (
    output req, req_pos, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who,
    input  play, plyr_pos, pc, comp_pos, busy, illegal, game_end
  );
endinterface

// File: rtl/ttt_line_eval.sv
// Evaluates one board line: two computer marks + a hole, two player marks + a hole,
// and the index of the lowest empty cell in the line.
module ttt_line_eval
  import ttt_pkg::*;
(
  input  logic [1:0] c0, c1, c2,
  input  logic [3:0] i0, i1, i2,
  output logic       comp_two,
  output logic       plyr_two,
  output logic [3:0] empty_idx
);

  logic [1:0] nc, np, ne;

  // Count marks per owner and locate the hole.
  always_comb begin
    nc = {1'b0, c0 == CELL_COMP}  + {1'b0, c1 == CELL_COMP}  + {1'b0, c2 == CELL_COMP};
    np = {1'b0, c0 == CELL_PLYR}  + {1'b0, c1 == CELL_PLYR}  + {1'b0, c2 == CELL_PLYR};
    ne = {1'b0, c0 == CELL_EMPTY} + {1'b0, c1 == CELL_EMPTY} + {1'b0, c2 == CELL_EMPTY};
    empty_idx = NULL_POS;
    if (c2 == CELL_EMPTY) empty_idx = i2;
    if (c1 == CELL_EMPTY) empty_idx = i1;
    if (c0 == CELL_EMPTY) empty_idx = i0;
    comp_two = (nc == 2'd2) && (ne == 2'd1);
    plyr_two = (np == 2'd2) && (ne == 2'd1);
  end

endmodule

// File: rtl/ttt_auto_opponent.sv
// Computer player: forwards the human move, waits for the game to apply it,
// scans the eight lines one per cycle and strobes a reply once per turn.
module ttt_auto_opponent
  import ttt_pkg::*;
#(
  parameter int SETTLE_CYC   = 2,
  parameter int CENTER_FIRST = 1
) (
  input  logic               clk,
  input  logic               reset,
  ttt_auto_opponent_if.slave bus
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t          state, state_n;
  logic [8:0][1:0] brd, snap, brd_q;
  logic [SW-1:0]   scnt;
  logic [2:0]      lc;
  logic [3:0]      win_cell, blk_cell, emp_cnt, live_cnt;
  logic            win_vld, blk_vld;
  logic            ill_q, gend_q;
  logic [3:0]      ppos_q, cpos_q;
  logic            req_ok, rejected;
  logic            comp_two, plyr_two;
  logic [3:0]      line_hole, low_idx, pick_cell;

  assign brd = {bus.pos9, bus.pos8, bus.pos7, bus.pos6, bus.pos5,
                bus.pos4, bus.pos3, bus.pos2, bus.pos1};

  assign live_cnt = count_empty(brd);
  assign req_ok   = bus.req && (bus.req_pos <= 4'd8) && !gend_q;
  // An unchanged board after settling means the game refused the move.
  assign rejected = (state == ST_CHECK) && (brd == snap);

  ttt_line_eval u_line (
    .c0        (brd_q[LINE_TBL[lc][0]]),
    .c1        (brd_q[LINE_TBL[lc][1]]),
    .c2        (brd_q[LINE_TBL[lc][2]]),
    .i0        (LINE_TBL[lc][0]),
    .i1        (LINE_TBL[lc][1]),
    .i2        (LINE_TBL[lc][2]),
    .comp_two  (comp_two),
    .plyr_two  (plyr_two),
    .empty_idx (line_hole)
  );

  // Reply choice: win, then block, then centre, then lowest free cell.
  always_comb begin
    low_idx = NULL_POS;
    for (int i = 8; i >= 0; i--)
      if (brd_q[i] == CELL_EMPTY) low_idx = 4'(i);
    if (win_vld)                                         pick_cell = win_cell;
    else if (blk_vld)                                    pick_cell = blk_cell;
    else if ((CENTER_FIRST != 0) && (brd_q[4] == CELL_EMPTY)) pick_cell = 4'd4;
    else                                                 pick_cell = low_idx;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (req_ok) state_n = ST_PLAY;
      ST_PLAY:   state_n = ST_SETTLE;
      ST_SETTLE: if (scnt == '0) state_n = ST_CHECK;
      ST_CHECK: begin
        if (rejected)                                  state_n = ST_IDLE;
        else if ((bus.who != 2'b00) || (live_cnt == 4'd0)) state_n = ST_ISSUE;
        else                                           state_n = ST_SCAN;
      end
      ST_SCAN:   if (lc == 3'd7) state_n = ST_PICK;
      ST_PICK:   state_n = ST_ISSUE;
      ST_ISSUE:  state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Datapath: request latch, settle/line counters, scan results, reply and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap     <= '0;
      brd_q    <= '0;
      scnt     <= '0;
      lc       <= '0;
      win_cell <= '0;
      blk_cell <= '0;
      win_vld  <= 1'b0;
      blk_vld  <= 1'b0;
      emp_cnt  <= '0;
      ill_q    <= 1'b0;
      gend_q   <= 1'b0;
      ppos_q   <= '0;
      cpos_q   <= '0;
    end else begin
      ill_q <= 1'b0;
      case (state)
        ST_IDLE: if (bus.req) begin
          if (req_ok) begin
            ppos_q <= bus.req_pos;
            snap   <= brd;
          end else begin
            ill_q  <= 1'b1;
          end
        end
        ST_PLAY:   scnt <= SW'(SETTLE_CYC - 1);
        ST_SETTLE: if (scnt != '0) scnt <= scnt - SW'(1);
        ST_CHECK: begin
          brd_q   <= brd;
          emp_cnt <= live_cnt;
          lc      <= '0;
          win_vld <= 1'b0;
          blk_vld <= 1'b0;
          // Null move still releases the game's computer-turn state.
          if (!rejected && ((bus.who != 2'b00) || (live_cnt == 4'd0))) begin
            cpos_q <= NULL_POS;
            gend_q <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (lc != 3'd7) lc <= lc + 3'd1;
          if (!win_vld && comp_two) begin
            win_vld  <= 1'b1;
            win_cell <= line_hole;
          end
          if (!blk_vld && plyr_two) begin
            blk_vld  <= 1'b1;
            blk_cell <= line_hole;
          end
        end
        ST_PICK: begin
          cpos_q <= pick_cell;
          if (win_vld || (emp_cnt == 4'd1)) gend_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.play     = (state == ST_PLAY);
  assign bus.pc       = (state == ST_ISSUE);
  assign bus.busy     = (state != ST_IDLE);
  assign bus.illegal  = ill_q | rejected;
  assign bus.game_end = gend_q;
  assign bus.plyr_pos = ppos_q;
  assign bus.comp_pos = cpos_q;

endmodule

// File: tb/tb_ttt_auto_opponent.sv
// Scoreboard bench for ttt_auto_opponent: the bench plays the game core, stimulus
// queues expected replies, a monitor checks every pc/illegal event as it appears.
module tb_ttt_auto_opponent;
  import ttt_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ttt_auto_opponent_if bus();

  ttt_auto_opponent #(.SETTLE_CYC(2), .CENTER_FIRST(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [1:0] board [9];
  logic [1:0] who;
  logic       req;
  logic [3:0] req_pos;

  assign bus.pos1 = board[0];
  assign bus.pos2 = board[1];
  assign bus.pos3 = board[2];
  assign bus.pos4 = board[3];
  assign bus.pos5 = board[4];
  assign bus.pos6 = board[5];
  assign bus.pos7 = board[6];
  assign bus.pos8 = board[7];
  assign bus.pos9 = board[8];
  assign bus.who     = who;
  assign bus.req     = req;
  assign bus.req_pos = req_pos;

  typedef struct {
    bit         is_ill;
    logic [3:0] cpos;
    int         lat;
    logic       gend;
    logic [3:0] ppos;
    int         rcyc;
  } exp_t;

  exp_t sbq [$];
  exp_t me;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   prun  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: play width, and every pc/illegal event against the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.play) prun++;
      else if (prun != 0) begin
        chk("play_width", prun, 1);
        prun = 0;
      end
      if (bus.pc || bus.illegal) begin
        if (sbq.size() == 0) chk("unexpected_event", {bus.pc, bus.illegal}, 0);
        else begin
          me = sbq.pop_front();
          chk("event_illegal", bus.illegal, me.is_ill);
          chk("event_pc", bus.pc, !me.is_ill);
          if (!me.is_ill) begin
            chk("comp_pos", bus.comp_pos, me.cpos);
            chk("latency", cyc - me.rcyc + 1, me.lat);
            chk("game_end", bus.game_end, me.gend);
            chk("plyr_pos", bus.plyr_pos, me.ppos);
            chk("pc_play_excl", bus.play, 0);
          end
        end
      end
    end else begin
      prun = 0;
    end
  end

  task automatic clear_board();
    for (int i = 0; i < 9; i++) board[i] = CELL_EMPTY;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_play", bus.play, 0);
    chk("rst_pc", bus.pc, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_game_end", bus.game_end, 0);
    chk("rst_comp_pos", bus.comp_pos, 0);
    chk("rst_plyr_pos", bus.plyr_pos, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Drive one request; optionally let the game core apply the move on the play pulse.
  task automatic issue(input logic [3:0] pos, input bit apply, input bit push, input bit ill,
                       input logic [3:0] cpos, input int lat, input logic gend);
    exp_t e;
    @(negedge clk);
    req = 1'b1;
    req_pos = pos;
    if (push) begin
      e.is_ill = ill;
      e.cpos   = cpos;
      e.lat    = lat;
      e.gend   = gend;
      e.ppos   = pos;
      e.rcyc   = cyc + 1;
      sbq.push_back(e);
    end
    @(negedge clk);
    req = 1'b0;
    if (apply && bus.play) board[pos] = CELL_PLYR;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((bus.busy || sbq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < 200, 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    req = 1'b0;
    req_pos = '0;
    who = 2'b00;
    clear_board();
    @(negedge clk);
    do_reset();

    // Empty board, centre reply, full latency.
    issue(4'd0, 1, 1, 0, 4'd4, 14, 1'b0);
    wait_done("t1_done");

    // Win beats block.
    do_reset();
    clear_board();
    board[0] = CELL_COMP; board[1] = CELL_COMP;
    board[3] = CELL_PLYR; board[4] = CELL_PLYR;
    issue(4'd8, 1, 1, 0, 4'd2, 14, 1'b1);
    wait_done("t2_done");

    // Block.
    do_reset();
    clear_board();
    board[0] = CELL_PLYR; board[1] = CELL_PLYR; board[4] = CELL_COMP;
    issue(4'd8, 1, 1, 0, 4'd2, 14, 1'b0);
    wait_done("t3_done");

    // Game refuses the move: board unchanged.
    issue(4'd3, 0, 1, 1, 4'd0, 0, 1'b0);
    wait_done("t4_done");

    // Out-of-range cell index rejected in IDLE.
    issue(4'd9, 0, 1, 1, 4'd0, 0, 1'b0);
    wait_done("t4b_done");

    // Centre taken, no threats: lowest free cell.
    clear_board();
    board[4] = CELL_COMP;
    issue(4'd0, 1, 1, 0, 4'd1, 14, 1'b0);
    wait_done("t8_done");

    // Player fills the last cell: null move, short latency, game over.
    clear_board();
    board[0] = CELL_PLYR; board[1] = CELL_COMP; board[2] = CELL_PLYR;
    board[3] = CELL_PLYR; board[4] = CELL_COMP; board[5] = CELL_COMP;
    board[6] = CELL_COMP; board[7] = CELL_PLYR;
    issue(4'd8, 1, 1, 0, NULL_POS, 5, 1'b1);
    wait_done("t5_done");
    issue(4'd0, 0, 1, 1, 4'd0, 0, 1'b1);
    wait_done("t5_after_end");

    // Winner reported by the game core: null move.
    do_reset();
    clear_board();
    board[0] = CELL_PLYR; board[1] = CELL_PLYR;
    who = 2'b01;
    issue(4'd2, 1, 1, 0, NULL_POS, 5, 1'b1);
    wait_done("t7_done");
    who = 2'b00;

    // Reset mid-scan, then a normal turn.
    do_reset();
    clear_board();
    issue(4'd2, 1, 0, 0, 4'd0, 0, 1'b0);
    repeat (6) @(negedge clk);
    chk("t6_busy_in_scan", bus.busy, 1);
    do_reset();
    clear_board();
    issue(4'd2, 1, 1, 0, 4'd4, 14, 1'b0);
    wait_done("t6_done");

    chk("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
